// File: rtl/window_3x3_gen.sv
// Purpose : streaming 3x3 neighbourhood generator feeding the edge-detection convolution stage.
// Latency : 1 cycle from accepted pixel (row>=2, col>=2) to window valid; o_frame_done rides the last window.
// Backpr. : none; a pixel may be accepted every cycle, and i_pixel_valid=0 cycles freeze all state.
//
// Ports:
//   i_clk, i_rstn       clock, asynchronous active-low reset
//   i_pixel[7:0]        greyscale pixel, raster order, taken when i_pixel_valid=1
//   o_pixel_data[71:0]  window; byte k at [k*8 +: 8], bytes 0-2 row r-2, 3-5 row r-1, 6-8 row r,
//                       oldest column first, byte 8 = newest pixel; held between windows
//   o_pixel_data_valid  one-cycle pulse per emitted window
//   o_frame_done        one-cycle pulse coincident with the last window of a frame
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 10
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [7:0]  i_pixel,
    input  logic        i_pixel_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_frame_done
);

    localparam int LB_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Window rows: byte 0 = column c-2 (oldest), byte 2 = column c (newest).
    logic [23:0] top_q, top_d;
    logic [23:0] mid_q, mid_d;
    logic [23:0] bot_q, bot_d;

    logic [71:0] data_q, data_d;
    logic        vld_q, vld_d;
    logic        done_q, done_d;

    // Line buffers are plain RAM: never reset, since stale contents are only
    // ever read while row < 2, when emission is gated off anyway.
    logic [7:0] lb_a_mem [0:IMG_WIDTH-1];
    logic [7:0] lb_b_mem [0:IMG_WIDTH-1];
    logic [7:0] lb_a_rd;
    logic [7:0] lb_b_rd;
    logic [LB_AW-1:0] lb_addr;

    logic last_col;
    logic last_row;
    logic in_window;

    assign lb_addr = col_q[LB_AW-1:0];
    assign lb_a_rd = lb_a_mem[lb_addr];
    assign lb_b_rd = lb_b_mem[lb_addr];

    assign last_col  = (col_q == COL_W'(IMG_WIDTH - 1));
    assign last_row  = (row_q == ROW_W'(IMG_HEIGHT - 1));
    // Column gate also suppresses windows straddling a row boundary, so the
    // shift registers never need clearing at row or frame edges.
    assign in_window = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        top_d  = top_q;
        mid_d  = mid_q;
        bot_d  = bot_q;
        data_d = data_q;
        vld_d  = 1'b0;
        done_d = 1'b0;

        if (i_pixel_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            top_d = {lb_a_rd, top_q[23:8]};
            mid_d = {lb_b_rd, mid_q[23:8]};
            bot_d = {i_pixel, bot_q[23:8]};

            if (in_window) begin
                vld_d  = 1'b1;
                data_d = {bot_d, mid_d, top_d};
            end
            // The final pixel of a frame is always inside the window region.
            done_d = last_col && last_row;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_q  <= '0;
            row_q  <= '0;
            top_q  <= '0;
            mid_q  <= '0;
            bot_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            top_q  <= top_d;
            mid_q  <= mid_d;
            bot_q  <= bot_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    // Row r-1 ages into the r-2 buffer as row r overwrites the r-1 buffer;
    // reads above see the pre-write contents in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_pixel_valid) begin
            lb_a_mem[lb_addr] <= lb_b_rd;
            lb_b_mem[lb_addr] <= i_pixel;
        end
    end

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = vld_q;
    assign o_frame_done       = done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 4;

    localparam logic [71:0] FIRST_W = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] LAST_W  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
    localparam logic [71:0] F2_W    = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};

    typedef struct packed {
        logic [71:0] win;
        logic        fd;
        logic [31:0] cyc;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [7:0]  i_pixel = 8'd0;
    logic        i_pixel_valid = 1'b0;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_frame_done;

    window_3x3_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (3),
        .ROW_W     (3)
    ) dut (
        .i_clk             (i_clk),
        .i_rstn            (i_rstn),
        .i_pixel           (i_pixel),
        .i_pixel_valid     (i_pixel_valid),
        .o_pixel_data      (o_pixel_data),
        .o_pixel_data_valid(o_pixel_data_valid),
        .o_frame_done      (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] cyc = 32'd0;
    exp_t        exp_q[$];
    logic [71:0] win_log[$];
    int          fd_cnt = 0;
    logic [71:0] held = 72'd0;
    logic [7:0]  img [0:H-1][0:W-1];
    int          m_row = 0;
    int          m_col = 0;

    always @(posedge i_clk) cyc <= cyc + 32'd1;

    // Scoreboard monitor: every window must match the oldest expectation,
    // arrive in the predicted cycle, and the output must hold between windows.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (!i_rstn) begin
            held = 72'd0;
        end else if (o_pixel_data_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL window_unexpected: got window %h, expected none pending", o_pixel_data);
            end else begin
                e = exp_q.pop_front();
                if (o_pixel_data !== e.win) begin
                    failures++;
                    $display("FAIL window_data: got %h expected %h", o_pixel_data, e.win);
                end
                checks++;
                if (o_frame_done !== e.fd) begin
                    failures++;
                    $display("FAIL frame_done_with_window: got %b expected %b", o_frame_done, e.fd);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL window_latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
                end
            end
            win_log.push_back(o_pixel_data);
            held = o_pixel_data;
        end else begin
            checks++;
            if (o_pixel_data !== held) begin
                failures++;
                $display("FAIL data_hold: got %h expected %h", o_pixel_data, held);
            end
            checks++;
            if (o_frame_done !== 1'b0) begin
                failures++;
                $display("FAIL frame_done_alone: got %b expected 0", o_frame_done);
            end
        end
        if (i_rstn && o_frame_done) fd_cnt++;
    end

    task automatic send_pixel(input logic [7:0] p);
        exp_t e;
        @(negedge i_clk);
        i_pixel       = p;
        i_pixel_valid = 1'b1;
        img[m_row][m_col] = p;
        if (m_row >= 2 && m_col >= 2) begin
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(i*3+j)*8 +: 8] = img[m_row-2+i][m_col-2+j];
            e.fd  = (m_row == H-1) && (m_col == W-1);
            e.cyc = cyc + 32'd1;
            exp_q.push_back(e);
        end
        if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_pixel_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input int base, input int max_gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send_pixel(8'(base + 4*r + c));
                if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
            end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_pixel_data_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", o_pixel_data_valid);
        end
        checks++;
        if (o_pixel_data !== 72'd0) begin
            failures++; $display("FAIL reset_data: got %h expected 0", o_pixel_data);
        end
        checks++;
        if (o_frame_done !== 1'b0) begin
            failures++; $display("FAIL reset_frame_done: got %b expected 0", o_frame_done);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    task automatic test_basic;
        win_log.delete(); fd_cnt = 0;
        send_frame(0, 0);
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL basic_missing: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (win_log.size() != 4) begin
            failures++; $display("FAIL basic_count: got %0d expected 4", win_log.size());
        end
        checks++;
        if (fd_cnt != 1) begin
            failures++; $display("FAIL basic_frame_done: got %0d expected 1", fd_cnt);
        end
        if (win_log.size() == 4) begin
            checks++;
            if (win_log[0] !== FIRST_W) begin
                failures++; $display("FAIL basic_first: got %h expected %h", win_log[0], FIRST_W);
            end
            checks++;
            if (win_log[3] !== LAST_W) begin
                failures++; $display("FAIL basic_last: got %h expected %h", win_log[3], LAST_W);
            end
        end
    endtask

    task automatic test_gaps;
        win_log.delete(); fd_cnt = 0;
        send_frame(0, 3);
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL gaps_missing: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (win_log.size() != 4) begin
            failures++; $display("FAIL gaps_count: got %0d expected 4", win_log.size());
        end
        checks++;
        if (fd_cnt != 1) begin
            failures++; $display("FAIL gaps_frame_done: got %0d expected 1", fd_cnt);
        end
        if (win_log.size() == 4) begin
            checks++;
            if (win_log[0] !== FIRST_W) begin
                failures++; $display("FAIL gaps_first: got %h expected %h", win_log[0], FIRST_W);
            end
            checks++;
            if (win_log[3] !== LAST_W) begin
                failures++; $display("FAIL gaps_last: got %h expected %h", win_log[3], LAST_W);
            end
        end
    endtask

    task automatic test_back_to_back;
        win_log.delete(); fd_cnt = 0;
        send_frame(0, 0);
        send_frame(100, 0);
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_missing: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (win_log.size() != 8) begin
            failures++; $display("FAIL b2b_count: got %0d expected 8", win_log.size());
        end
        checks++;
        if (fd_cnt != 2) begin
            failures++; $display("FAIL b2b_frame_done: got %0d expected 2", fd_cnt);
        end
        if (win_log.size() == 8) begin
            checks++;
            if (win_log[3] !== LAST_W) begin
                failures++; $display("FAIL b2b_f1_last: got %h expected %h", win_log[3], LAST_W);
            end
            checks++;
            if (win_log[4] !== F2_W) begin
                failures++; $display("FAIL b2b_f2_first: got %h expected %h", win_log[4], F2_W);
            end
        end
    endtask

    task automatic test_reset_mid;
        // Pixels (0,0) .. (2,3) of the 4r+c image.
        for (int k = 0; k < 12; k++) send_pixel(8'(k));
        @(posedge i_clk);
        #2;
        i_rstn        = 1'b0;
        i_pixel_valid = 1'b0;
        exp_q.delete();
        win_log.delete();
        fd_cnt = 0;
        m_row  = 0;
        m_col  = 0;
        #1;
        checks++;
        if (o_pixel_data_valid !== 1'b0) begin
            failures++; $display("FAIL midreset_valid: got %b expected 0", o_pixel_data_valid);
        end
        checks++;
        if (o_pixel_data !== 72'd0) begin
            failures++; $display("FAIL midreset_data: got %h expected 0", o_pixel_data);
        end
        checks++;
        if (o_frame_done !== 1'b0) begin
            failures++; $display("FAIL midreset_frame_done: got %b expected 0", o_frame_done);
        end
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        send_frame(0, 0);
        idle(3);
        checks++;
        if (win_log.size() != 4) begin
            failures++; $display("FAIL midreset_count: got %0d expected 4", win_log.size());
        end
        checks++;
        if (fd_cnt != 1) begin
            failures++; $display("FAIL midreset_frame_done_cnt: got %0d expected 1", fd_cnt);
        end
        if (win_log.size() == 4) begin
            checks++;
            if (win_log[0] !== FIRST_W) begin
                failures++; $display("FAIL midreset_first: got %h expected %h", win_log[0], FIRST_W);
            end
            checks++;
            if (win_log[3] !== LAST_W) begin
                failures++; $display("FAIL midreset_last: got %h expected %h", win_log[3], LAST_W);
            end
        end
    endtask

    task automatic test_ramp_random;
        win_log.delete(); fd_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) send_pixel(8'((r + c) % 256));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send_pixel(8'($urandom));
                if ((r + c) % 3 == 0) idle(int'($urandom_range(2, 0)));
            end
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL ramp_missing: got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (win_log.size() != 8) begin
            failures++; $display("FAIL ramp_count: got %0d expected 8", win_log.size());
        end
        checks++;
        if (fd_cnt != 2) begin
            failures++; $display("FAIL ramp_frame_done: got %0d expected 2", fd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_ramp_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
